// File: rtl/capture_buffer_if.sv
// Capture buffer bus: sample input, control pulses, read-back port and status.
// master drives arm/stop/data_valid/data/rd_addr and observes the status/read-back outputs.
// slave is the capture_buffer side of the same bundle.
interface capture_buffer_if #(
   parameter int WIDTH = 40,
   parameter int DEPTH = 12
);
   localparam int AW = $clog2(DEPTH);

   logic             arm;
   logic             stop;
   logic             data_valid;
   logic [WIDTH-1:0] data;
   logic [AW-1:0]    rd_addr;
   logic [WIDTH-1:0] rd_data;
   logic [AW:0]      count;
   logic [AW-1:0]    wr_ptr;
   logic             busy;
   logic             done;
   logic             wrapped;

   modport master (
      output arm, stop, data_valid, data, rd_addr,
      input  rd_data, count, wr_ptr, busy, done, wrapped
   );

   modport slave (
      input  arm, stop, data_valid, data, rd_addr,
      output rd_data, count, wr_ptr, busy, done, wrapped
   );
endinterface

// File: rtl/capture_buffer.sv
// Sample-capture memory: records up to DEPTH qualified samples after arm, stops on full or stop.
// Latency: a sample written at edge N is readable via rd_addr one edge later; rd_data is 1 cycle behind rd_addr.
// Backpressure: none; samples offered outside CAPTURE, or after a one-shot fill, are dropped.
// Ports: clk, reset (async active-low, released synchronously), bus (capture_buffer_if.slave):
//   arm/stop/data_valid/data in, rd_addr in, rd_data/count/wr_ptr/busy/done/wrapped out.
// Build option: define CAPTURE_WRAP_EN for circular "last DEPTH samples" recording;
//   without it the buffer is one-shot and wrapped is tied low.
module capture_buffer #(
   parameter int WIDTH = 40,
   parameter int DEPTH = 12
) (
   input  logic              clk,
   input  logic              reset,
   capture_buffer_if.slave   bus
);
   localparam int AW = $clog2(DEPTH);

   // Encoding chosen so busy and done are straight flop bits.
   localparam logic [1:0] ST_IDLE    = 2'b00;
   localparam logic [1:0] ST_CAPTURE = 2'b01;
   localparam logic [1:0] ST_DONE    = 2'b10;

   localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
   localparam logic [AW:0]   CNT_LAST = (AW+1)'(DEPTH - 1);
   localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);

   // Reset: asserts immediately, releases on the second clk edge after reset goes high.
   logic rst_meta_q;
   logic rst_sync_n_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rst_meta_q   <= 1'b0;
         rst_sync_n_q <= 1'b0;
      end else begin
         rst_meta_q   <= 1'b1;
         rst_sync_n_q <= rst_meta_q;
      end
   end

   logic [1:0]       state_q,   state_d;
   logic [AW-1:0]    wr_ptr_q,  wr_ptr_d;
   logic [AW:0]      count_q,   count_d;
   logic [WIDTH-1:0] rd_data_q, rd_data_d;
   logic             mem_we;
   logic [WIDTH-1:0] mem_q [DEPTH];

`ifdef CAPTURE_WRAP_EN
   logic             wrapped_q, wrapped_d;
`endif

   always_comb begin
      state_d  = state_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      mem_we   = 1'b0;
`ifdef CAPTURE_WRAP_EN
      wrapped_d = wrapped_q;
`endif
      // arm restarts from any state and takes priority over stop and the current sample.
      if (bus.arm) begin
         state_d  = ST_CAPTURE;
         wr_ptr_d = '0;
         count_d  = '0;
`ifdef CAPTURE_WRAP_EN
         wrapped_d = 1'b0;
`endif
      end else if (state_q == ST_CAPTURE) begin
         if (bus.data_valid) begin
            mem_we   = 1'b1;
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
            if (count_q != CNT_FULL) begin
               count_d = count_q + 1'b1;
            end
`ifdef CAPTURE_WRAP_EN
            // Writing into a full buffer overwrites the oldest entry.
            if (count_q == CNT_FULL) begin
               wrapped_d = 1'b1;
            end
`else
            // The write that fills the buffer ends capture on the same edge.
            if (count_q == CNT_LAST) begin
               state_d = ST_DONE;
            end
`endif
         end
         // A sample presented alongside stop has already been taken above.
         if (bus.stop) begin
            state_d = ST_DONE;
         end
      end
   end

   // Addresses past the last entry read as zero rather than aliasing.
   always_comb begin
      rd_data_d = '0;
      if ({1'b0, bus.rd_addr} < CNT_FULL) begin
         rd_data_d = mem_q[bus.rd_addr];
      end
   end

   always_ff @(posedge clk or negedge rst_sync_n_q) begin
      if (!rst_sync_n_q) begin
         state_q   <= ST_IDLE;
         wr_ptr_q  <= '0;
         count_q   <= '0;
         rd_data_q <= '0;
      end else begin
         state_q   <= state_d;
         wr_ptr_q  <= wr_ptr_d;
         count_q   <= count_d;
         rd_data_q <= rd_data_d;
      end
   end

`ifdef CAPTURE_WRAP_EN
   always_ff @(posedge clk or negedge rst_sync_n_q) begin
      if (!rst_sync_n_q) begin
         wrapped_q <= 1'b0;
      end else begin
         wrapped_q <= wrapped_d;
      end
   end
   assign bus.wrapped = wrapped_q;
`else
   assign bus.wrapped = 1'b0;
`endif

   // Storage is deliberately not reset. Reading and writing the same entry on one edge
   // returns the old contents because rd_data_q samples mem_q before this update lands.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem_q[wr_ptr_q] <= bus.data;
      end
   end

   assign bus.rd_data = rd_data_q;
   assign bus.count   = count_q;
   assign bus.wr_ptr  = wr_ptr_q;
   assign bus.busy    = state_q[0];
   assign bus.done    = state_q[1];
endmodule

// File: tb/tb_capture_buffer.sv
// Self-checking bench for capture_buffer: scenario tasks with a queue of expected read-back data.
module tb_capture_buffer;
   localparam int WIDTH = 40;
   localparam int DEPTH = 12;
   localparam int AW    = $clog2(DEPTH);
`ifdef CAPTURE_WRAP_EN
   localparam bit WRAP = 1'b1;
`else
   localparam bit WRAP = 1'b0;
`endif

   logic clk   = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   capture_buffer_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

   capture_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;
   logic [WIDTH-1:0] exp_q [$];

   // Drive one cycle of control/sample inputs; returns 1 time unit after the edge.
   task automatic cycle(input logic a, input logic s, input logic v, input logic [WIDTH-1:0] d);
      bus.arm        = a;
      bus.stop       = s;
      bus.data_valid = v;
      bus.data       = d;
      @(posedge clk);
      #1;
      bus.arm        = 1'b0;
      bus.stop       = 1'b0;
      bus.data_valid = 1'b0;
   endtask

   task automatic test_reset();
      repeat (3) cycle(1'b0, 1'b0, 1'b0, '0);
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", bus.busy); end
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b want 0", bus.done); end
      checks++; if (bus.count !== 0) begin errors++; $display("FAIL reset_count got %0d want 0", bus.count); end
      checks++; if (bus.wr_ptr !== 0) begin errors++; $display("FAIL reset_wr_ptr got %0d want 0", bus.wr_ptr); end
      checks++; if (bus.wrapped !== 1'b0) begin errors++; $display("FAIL reset_wrapped got %0b want 0", bus.wrapped); end
      checks++; if (bus.rd_data !== 0) begin errors++; $display("FAIL reset_rd_data got %0h want 0", bus.rd_data); end
      reset = 1'b1;
      repeat (3) cycle(1'b0, 1'b0, 1'b0, '0);
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %0b want 0", bus.busy); end
   endtask

   task automatic test_fill();
      logic [WIDTH-1:0] want;
      exp_q.delete();
      cycle(1'b1, 1'b0, 1'b0, '0);
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL fill_busy_arm got %0b want 1", bus.busy); end
      for (int i = 1; i <= DEPTH; i++) begin
         exp_q.push_back(WIDTH'(i));
         cycle(1'b0, 1'b0, 1'b1, WIDTH'(i));
         if (i == DEPTH - 1) begin
            checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL fill_done_early got %0b want 0", bus.done); end
         end
      end
      checks++; if (bus.count !== DEPTH) begin errors++; $display("FAIL fill_count got %0d want %0d", bus.count, DEPTH); end
      checks++; if (bus.wr_ptr !== 0) begin errors++; $display("FAIL fill_wr_ptr got %0d want 0", bus.wr_ptr); end
      checks++; if (bus.done !== !WRAP) begin errors++; $display("FAIL fill_done got %0b want %0b", bus.done, !WRAP); end
      checks++; if (bus.busy !== WRAP) begin errors++; $display("FAIL fill_busy got %0b want %0b", bus.busy, WRAP); end
      if (WRAP) cycle(1'b0, 1'b1, 1'b0, '0);
      for (int a = 0; a < DEPTH; a++) begin
         bus.rd_addr = AW'(a);
         @(posedge clk); #1;
         want = exp_q.pop_front();
         checks++; if (bus.rd_data !== want) begin errors++; $display("FAIL fill_rd[%0d] got %0h want %0h", a, bus.rd_data, want); end
      end
      bus.rd_addr = AW'(DEPTH);
      @(posedge clk); #1;
      checks++; if (bus.rd_data !== 0) begin errors++; $display("FAIL fill_rd_oor got %0h want 0", bus.rd_data); end
   endtask

   task automatic test_stop_alt();
      logic [WIDTH-1:0] want;
      exp_q.delete();
      cycle(1'b1, 1'b0, 1'b0, '0);
      for (int k = 0; k < 5; k++) begin
         exp_q.push_back(WIDTH'('h100 + k));
         cycle(1'b0, 1'b0, 1'b1, WIDTH'('h100 + k));
         cycle(1'b0, 1'b0, 1'b0, '0);
      end
      exp_q.push_back(WIDTH'('h105));
      cycle(1'b0, 1'b1, 1'b1, WIDTH'('h105));
      checks++; if (bus.count !== 6) begin errors++; $display("FAIL stop_count got %0d want 6", bus.count); end
      checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL stop_done got %0b want 1", bus.done); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL stop_busy got %0b want 0", bus.busy); end
      checks++; if (bus.wr_ptr !== 6) begin errors++; $display("FAIL stop_wr_ptr got %0d want 6", bus.wr_ptr); end
      cycle(1'b0, 1'b0, 1'b1, WIDTH'('hBAD));
      checks++; if (bus.count !== 6) begin errors++; $display("FAIL stop_hold_count got %0d want 6", bus.count); end
      for (int a = 0; a < 6; a++) begin
         bus.rd_addr = AW'(a);
         @(posedge clk); #1;
         want = exp_q.pop_front();
         checks++; if (bus.rd_data !== want) begin errors++; $display("FAIL stop_rd[%0d] got %0h want %0h", a, bus.rd_data, want); end
      end
   endtask

`ifdef CAPTURE_WRAP_EN
   task automatic test_wrap();
      logic [WIDTH-1:0] want;
      exp_q.delete();
      cycle(1'b1, 1'b0, 1'b0, '0);
      for (int v = 1; v <= 15; v++) begin
         cycle(1'b0, 1'b0, 1'b1, WIDTH'(v));
         if (v == DEPTH) begin
            checks++; if (bus.wrapped !== 1'b0) begin errors++; $display("FAIL wrap_early got %0b want 0", bus.wrapped); end
         end
         if (v == DEPTH + 1) begin
            checks++; if (bus.wrapped !== 1'b1) begin errors++; $display("FAIL wrap_first got %0b want 1", bus.wrapped); end
            checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL wrap_busy got %0b want 1", bus.busy); end
         end
      end
      cycle(1'b0, 1'b1, 1'b0, '0);
      checks++; if (bus.count !== DEPTH) begin errors++; $display("FAIL wrap_count got %0d want %0d", bus.count, DEPTH); end
      checks++; if (bus.wrapped !== 1'b1) begin errors++; $display("FAIL wrap_flag got %0b want 1", bus.wrapped); end
      checks++; if (bus.wr_ptr !== 3) begin errors++; $display("FAIL wrap_wr_ptr got %0d want 3", bus.wr_ptr); end
      checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL wrap_done got %0b want 1", bus.done); end
      exp_q.push_back(WIDTH'(4));
      bus.rd_addr = AW'(3);
      @(posedge clk); #1;
      want = exp_q.pop_front();
      checks++; if (bus.rd_data !== want) begin errors++; $display("FAIL wrap_oldest got %0h want %0h", bus.rd_data, want); end
      exp_q.push_back(WIDTH'(15));
      bus.rd_addr = AW'(2);
      @(posedge clk); #1;
      want = exp_q.pop_front();
      checks++; if (bus.rd_data !== want) begin errors++; $display("FAIL wrap_newest got %0h want %0h", bus.rd_data, want); end
   endtask
`else
   task automatic test_overflow();
      logic [WIDTH-1:0] want;
      exp_q.delete();
      cycle(1'b1, 1'b0, 1'b0, '0);
      for (int i = 0; i < 15; i++) begin
         if (i < DEPTH) exp_q.push_back(WIDTH'('h200 + i));
         cycle(1'b0, 1'b0, 1'b1, WIDTH'('h200 + i));
      end
      checks++; if (bus.count !== DEPTH) begin errors++; $display("FAIL ovf_count got %0d want %0d", bus.count, DEPTH); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL ovf_busy got %0b want 0", bus.busy); end
      checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL ovf_done got %0b want 1", bus.done); end
      checks++; if (bus.wr_ptr !== 0) begin errors++; $display("FAIL ovf_wr_ptr got %0d want 0", bus.wr_ptr); end
      checks++; if (bus.wrapped !== 1'b0) begin errors++; $display("FAIL ovf_wrapped got %0b want 0", bus.wrapped); end
      for (int a = 0; a < DEPTH; a++) begin
         bus.rd_addr = AW'(a);
         @(posedge clk); #1;
         want = exp_q.pop_front();
         checks++; if (bus.rd_data !== want) begin errors++; $display("FAIL ovf_rd[%0d] got %0h want %0h", a, bus.rd_data, want); end
      end
   endtask
`endif

   task automatic test_reset_mid();
      logic [WIDTH-1:0] want;
      exp_q.delete();
      cycle(1'b1, 1'b0, 1'b0, '0);
      for (int k = 0; k < 4; k++) cycle(1'b0, 1'b0, 1'b1, WIDTH'('h500 + k));
      checks++; if (bus.count !== 4) begin errors++; $display("FAIL rmid_count_pre got %0d want 4", bus.count); end
      bus.rd_addr = AW'(1);
      cycle(1'b0, 1'b0, 1'b0, '0);
      checks++; if (bus.rd_data !== WIDTH'('h501)) begin errors++; $display("FAIL rmid_rd_pre got %0h want 501", bus.rd_data); end
      #1 reset = 1'b0;
      #1;
      checks++; if (bus.count !== 0) begin errors++; $display("FAIL rmid_count got %0d want 0", bus.count); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got %0b want 0", bus.busy); end
      checks++; if (bus.rd_data !== 0) begin errors++; $display("FAIL rmid_rd_data got %0h want 0", bus.rd_data); end
      checks++; if (bus.wr_ptr !== 0) begin errors++; $display("FAIL rmid_wr_ptr got %0d want 0", bus.wr_ptr); end
      @(posedge clk); #1;
      reset = 1'b1;
      repeat (3) cycle(1'b0, 1'b0, 1'b0, '0);
      cycle(1'b1, 1'b0, 1'b0, '0);
      exp_q.push_back(WIDTH'('h600));
      cycle(1'b0, 1'b0, 1'b1, WIDTH'('h600));
      checks++; if (bus.wr_ptr !== 1) begin errors++; $display("FAIL rmid_rearm_ptr got %0d want 1", bus.wr_ptr); end
      checks++; if (bus.count !== 1) begin errors++; $display("FAIL rmid_rearm_count got %0d want 1", bus.count); end
      exp_q.push_back(WIDTH'('h501));
      for (int a = 0; a < 2; a++) begin
         bus.rd_addr = AW'(a);
         @(posedge clk); #1;
         want = exp_q.pop_front();
         checks++; if (bus.rd_data !== want) begin errors++; $display("FAIL rmid_rd[%0d] got %0h want %0h", a, bus.rd_data, want); end
      end
      cycle(1'b0, 1'b1, 1'b0, '0);
   endtask

   task automatic test_arm_stop_restart();
      logic [WIDTH-1:0] want;
      exp_q.delete();
      cycle(1'b1, 1'b0, 1'b0, '0);
      for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0, 1'b1, WIDTH'('h300 + k));
      cycle(1'b1, 1'b1, 1'b1, WIDTH'('hDEAD));
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL rst_arm_busy got %0b want 1", bus.busy); end
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL rst_arm_done got %0b want 0", bus.done); end
      checks++; if (bus.count !== 0) begin errors++; $display("FAIL rst_arm_count got %0d want 0", bus.count); end
      checks++; if (bus.wr_ptr !== 0) begin errors++; $display("FAIL rst_arm_wr_ptr got %0d want 0", bus.wr_ptr); end
      // Same entry read and written on one edge: old contents come back first.
      bus.rd_addr = AW'(0);
      exp_q.push_back(WIDTH'('h300));
      cycle(1'b0, 1'b0, 1'b1, WIDTH'('h400));
      want = exp_q.pop_front();
      checks++; if (bus.rd_data !== want) begin errors++; $display("FAIL rbw_old got %0h want %0h", bus.rd_data, want); end
      exp_q.push_back(WIDTH'('h400));
      cycle(1'b0, 1'b0, 1'b0, '0);
      want = exp_q.pop_front();
      checks++; if (bus.rd_data !== want) begin errors++; $display("FAIL rbw_new got %0h want %0h", bus.rd_data, want); end
      checks++; if (bus.count !== 1) begin errors++; $display("FAIL rbw_count got %0d want 1", bus.count); end
   endtask

   initial begin
      bus.arm        = 1'b0;
      bus.stop       = 1'b0;
      bus.data_valid = 1'b0;
      bus.data       = '0;
      bus.rd_addr    = '0;
      test_reset();
      test_fill();
      test_stop_alt();
`ifdef CAPTURE_WRAP_EN
      test_wrap();
`else
      test_overflow();
`endif
      test_reset_mid();
      test_arm_stop_restart();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
